// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Iterative RV64M multiply/divide unit for the EX stage.
//                Shift-add multiply and restoring divide on operand
//                magnitudes, one bit per cycle, with the sign fix-up applied
//                as the result is registered. Stalls the pipeline while busy.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_muldiv_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            ex_hold_i,
   input  logic            flush_i,
   output logic            stall_req_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int            HALF     = XLEN / 2;
   localparam int            CW       = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            w_q, w_d, div_q, div_d, rem_q, rem_d, high_q, high_d;
   logic            sa_q, sa_d, sb_q, sb_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [XLEN-1:0] opb_q, opb_d, res_q, res_d;

   // Decode signals for the instruction presented in the accept cycle
   logic            dec_w, dec_div, dec_rem, dec_high, dec_as, dec_bs;
   logic            dec_sa, dec_sb, b_zero, a_min, b_m1, ovf, shortcut;
   logic [HALF-1:0] a_lo, b_lo, neg_a_lo, neg_b_lo;
   logic [XLEN-1:0] neg_a, neg_b, a_mag, b_mag, a_sext, min_sext, short_res;

   // Iteration datapath and final result formatting
   logic [XLEN:0]     msum, dtrial;
   logic [XLEN-1:0]   ddiff, hi_n, lo_n, div_sel, div_fix, mul_res, div_res, final_res;
   logic              dge, div_neg;
   logic [2*XLEN-1:0] prod, prod_fix;

   // Decode op, take operand magnitudes and detect the divide shortcuts
   always_comb begin
      dec_w    = (op_i >= 4'd8) && (op_i <= 4'd12);
      dec_div  = op_i inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};
      dec_rem  = op_i inside {4'd6, 4'd7, 4'd11, 4'd12};
      dec_high = op_i inside {4'd1, 4'd2, 4'd3};
      dec_as   = op_i inside {4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 4'd11};
      dec_bs   = op_i inside {4'd1, 4'd4, 4'd6, 4'd9, 4'd11};
      a_lo     = rs1_i[HALF-1:0];
      b_lo     = rs2_i[HALF-1:0];
      neg_a    = -rs1_i;
      neg_b    = -rs2_i;
      neg_a_lo = -a_lo;
      neg_b_lo = -b_lo;
      dec_sa   = dec_as & (dec_w ? a_lo[HALF-1] : rs1_i[XLEN-1]);
      dec_sb   = dec_bs & (dec_w ? b_lo[HALF-1] : rs2_i[XLEN-1]);
      if (dec_w) begin
         a_mag = {{HALF{1'b0}}, (dec_sa ? neg_a_lo : a_lo)};
         b_mag = {{HALF{1'b0}}, (dec_sb ? neg_b_lo : b_lo)};
      end else begin
         a_mag = dec_sa ? neg_a : rs1_i;
         b_mag = dec_sb ? neg_b : rs2_i;
      end
      b_zero   = dec_w ? (b_lo == '0) : (rs2_i == '0);
      a_min    = dec_w ? (a_lo == {1'b1, {(HALF-1){1'b0}}}) : (rs1_i == {1'b1, {(XLEN-1){1'b0}}});
      b_m1     = dec_w ? (&b_lo) : (&rs2_i);
      ovf      = dec_div & dec_as & dec_bs & a_min & b_m1;
      shortcut = dec_div & (b_zero | ovf);
      a_sext   = dec_w ? {{HALF{a_lo[HALF-1]}}, a_lo} : rs1_i;
      min_sext = dec_w ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      if (b_zero) begin
         short_res = dec_rem ? a_sext : {XLEN{1'b1}};
      end else begin
         short_res = dec_rem ? {XLEN{1'b0}} : min_sext;
      end
   end

   // One multiply or divide step, plus the signed/width fix-up of its outcome
   always_comb begin
      msum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
      dtrial = {acc_hi_q, acc_lo_q[XLEN-1]};
      dge    = dtrial >= {1'b0, opb_q};
      // When the trial fits, the true difference is below 2^XLEN
      ddiff  = dtrial[XLEN-1:0] - opb_q;
      if (div_q) begin
         hi_n = dge ? ddiff : dtrial[XLEN-1:0];
         lo_n = {acc_lo_q[XLEN-2:0], dge};
      end else begin
         hi_n = msum[XLEN:1];
         lo_n = {msum[0], acc_lo_q[XLEN-1:1]};
      end
      // A W multiply leaves its product shifted up by HALF bits
      prod     = {hi_n, lo_n};
      prod_fix = (sa_q ^ sb_q) ? -prod : prod;
      if (w_q) begin
         mul_res = {{HALF{prod_fix[XLEN-1]}}, prod_fix[XLEN-1:HALF]};
      end else begin
         mul_res = high_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
      end
      div_sel   = rem_q ? hi_n : lo_n;
      div_neg   = rem_q ? sa_q : (sa_q ^ sb_q);
      div_fix   = div_neg ? -div_sel : div_sel;
      div_res   = w_q ? {{HALF{div_fix[HALF-1]}}, div_fix[HALF-1:0]} : div_fix;
      final_res = div_q ? div_res : mul_res;
   end

   // Next-state, stall/valid outputs and datapath register updates
   always_comb begin
      state_d        = state_q;
      stall_req_o    = 1'b0;
      result_valid_o = 1'b0;
      w_d            = w_q;
      div_d          = div_q;
      rem_d          = rem_q;
      high_d         = high_q;
      sa_d           = sa_q;
      sb_d           = sb_q;
      cnt_d          = cnt_q;
      acc_hi_d       = acc_hi_q;
      acc_lo_d       = acc_lo_q;
      opb_d          = opb_q;
      res_d          = res_q;
      unique case (state_q)
         S_IDLE: begin
            if (valid_i && !flush_i) begin
               stall_req_o = 1'b1;
               w_d         = dec_w;
               div_d       = dec_div;
               rem_d       = dec_rem;
               high_d      = dec_high;
               sa_d        = dec_sa;
               sb_d        = dec_sb;
               cnt_d       = dec_w ? CNT_HALF : CNT_FULL;
               if (shortcut) begin
                  res_d   = short_res;
                  state_d = S_DONE;
               end else begin
                  state_d  = S_CALC;
                  acc_hi_d = '0;
                  if (dec_div) begin
                     // W dividend sits in the top half so its MSB leads
                     acc_lo_d = dec_w ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                     opb_d    = b_mag;
                  end else begin
                     acc_lo_d = b_mag;
                     opb_d    = a_mag;
                  end
               end
            end
         end
         S_CALC: begin
            stall_req_o = 1'b1;
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               acc_hi_d = hi_n;
               acc_lo_d = lo_n;
               cnt_d    = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  res_d   = final_res;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               result_valid_o = 1'b1;
               if (!ex_hold_i) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Operand, accumulator, counter and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q      <= 1'b0;
         div_q    <= 1'b0;
         rem_q    <= 1'b0;
         high_q   <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opb_q    <= '0;
         res_q    <= '0;
      end else begin
         w_q      <= w_d;
         div_q    <= div_d;
         rem_q    <= rem_d;
         high_q   <= high_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opb_q    <= opb_d;
         res_q    <= res_d;
      end
   end

   assign result_o = res_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_unit
//  Description : Self-checking bench for ex_muldiv_unit: directed M-extension
//                cases, flush, hold, reset and randomized ops against an
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [3:0]  op_i;
   logic [63:0] rs1_i;
   logic [63:0] rs2_i;
   logic        ex_hold_i;
   logic        flush_i;
   logic        stall_req_o;
   logic        result_valid_o;
   logic [63:0] result_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.XLEN(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (valid_i),
      .op_i           (op_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .ex_hold_i      (ex_hold_i),
      .flush_i        (flush_i),
      .stall_req_o    (stall_req_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o)
   );

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Architectural result of an RV64M op, from plain arithmetic
   function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      logic [31:0]  a32, b32;
      logic [63:0]  r;
      longint       sa, sb;
      int           sa32, sb32;
      logic         ovf64, ovf32;
      a32   = a[31:0];
      b32   = b[31:0];
      sa    = a;
      sb    = b;
      sa32  = a32;
      sb32  = b32;
      ovf64 = (a == MIN64) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
      ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
      case (op)
         4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
         4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
         4'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
         4'd4: begin
            if (b == 0)     r = 64'hFFFF_FFFF_FFFF_FFFF;
            else if (ovf64) r = MIN64;
            else            r = sa / sb;
         end
         4'd5: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
         4'd6: begin
            if (b == 0)     r = a;
            else if (ovf64) r = 64'd0;
            else            r = sa % sb;
         end
         4'd7: r = (b == 0) ? a : a % b;
         4'd8: r = sx32(a32 * b32);
         4'd9: begin
            if (b32 == 0)   r = 64'hFFFF_FFFF_FFFF_FFFF;
            else if (ovf32) r = sx32(32'h8000_0000);
            else            r = sx32(32'(sa32 / sb32));
         end
         4'd10: r = (b32 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : sx32(a32 / b32);
         4'd11: begin
            if (b32 == 0)   r = sx32(a32);
            else if (ovf32) r = 64'd0;
            else            r = sx32(32'(sa32 % sb32));
         end
         4'd12: r = (b32 == 0) ? sx32(a32) : sx32(a32 % b32);
         default: r = a * b;
      endcase
      return r;
   endfunction

   // Number of cycles stall_req_o should be high for an op
   function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      logic w, divop, zero, ovf;
      w     = (op >= 4'd8) && (op <= 4'd12);
      divop = (op >= 4'd4 && op <= 4'd7) || (op >= 4'd9 && op <= 4'd12);
      zero  = w ? (b[31:0] == 0) : (b == 0);
      ovf   = ((op == 4'd4 || op == 4'd6) && a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF) ||
              ((op == 4'd9 || op == 4'd11) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      if (divop && (zero || ovf)) return 1;
      return w ? 33 : 65;
   endfunction

   function automatic logic [63:0] pick();
      logic [63:0] v;
      case ($urandom_range(0, 7))
         0:       v = 64'd0;
         1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
         2:       v = MIN64;
         3:       v = 64'h0000_0000_8000_0000;
         4:       v = 64'($urandom_range(0, 50));
         5:       v = {32'h0, $urandom()};
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   // Issue one op, count its stall cycles, check DONE for `dones` cycles, release
   task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int dones, input string tag);
      logic [63:0] exp;
      int          lat;
      int          n;
      exp = ref_res(op, a, b);
      lat = ref_lat(op, a, b);
      @(negedge clk);
      valid_i   = 1'b1;
      op_i      = op;
      rs1_i     = a;
      rs2_i     = b;
      ex_hold_i = 1'b1;
      flush_i   = 1'b0;
      #1;
      n = 0;
      while (stall_req_o === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      check({tag, " stall_cycles"}, 64'(n), 64'(lat));
      check({tag, " result_valid"}, 64'(result_valid_o), 64'd1);
      check({tag, " result"}, result_o, exp);
      for (int i = 1; i < dones; i++) begin
         @(negedge clk);
         #1;
         check({tag, " held_valid"}, 64'(result_valid_o), 64'd1);
         check({tag, " held_stall"}, 64'(stall_req_o), 64'd0);
         check({tag, " held_result"}, result_o, exp);
      end
      ex_hold_i = 1'b0;
   endtask

   task automatic go_idle(input string tag);
      @(negedge clk);
      valid_i   = 1'b0;
      ex_hold_i = 1'b0;
      #1;
      check({tag, " idle_valid"}, 64'(result_valid_o), 64'd0);
      check({tag, " idle_stall"}, 64'(stall_req_o), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      logic [3:0] rop;
      rst = 1'b1; valid_i = 1'b0; op_i = 4'd0; rs1_i = '0; rs2_i = '0;
      ex_hold_i = 1'b0; flush_i = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset stall", 64'(stall_req_o), 64'd0);
      check("reset valid", 64'(result_valid_o), 64'd0);
      check("reset result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(4'd0, 64'd7, -64'd3, 1, "mul_7x-3");
      go_idle("mul_7x-3");
      do_op(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, "mulhu_ones");
      do_op(4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, "mulh_-1x-1");
      do_op(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1, "mulhsu_-1x2");
      do_op(4'd4, -64'd20, 64'd3, 1, "div_-20/3");
      do_op(4'd6, -64'd20, 64'd3, 1, "rem_-20/3");
      do_op(4'd10, 64'h1_8000_0000, 64'd1, 1, "divuw");
      do_op(4'd4, 64'd12345, 64'd0, 1, "div_by0");
      do_op(4'd7, 64'd12345, 64'd0, 1, "remu_by0");
      do_op(4'd4, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div_ovf");
      do_op(4'd6, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 1, "rem_ovf");
      do_op(4'd11, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, "remw_ovf");
      do_op(4'd8, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 1, "mulw_wrap");
      do_op(4'd14, 64'd9, 64'd11, 1, "reserved_as_mul");
      go_idle("directed");

      // Hold in DONE for five cycles; no restart afterwards
      do_op(4'd5, 64'd1000, 64'd7, 5, "divu_hold");
      go_idle("divu_hold");

      // Flush in the tenth CALC cycle
      @(negedge clk);
      valid_i = 1'b1; op_i = 4'd4; rs1_i = 64'd100; rs2_i = 64'd7; ex_hold_i = 1'b1;
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      valid_i = 1'b0;
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      check("flush stall", 64'(stall_req_o), 64'd0);
      check("flush valid", 64'(result_valid_o), 64'd0);
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         #1;
         if (result_valid_o !== 1'b0 || stall_req_o !== 1'b0) seen++;
      end
      check("flush no_result", 64'(seen), 64'd0);
      ex_hold_i = 1'b0;

      // Back-to-back multiplies
      do_op(4'd0, 64'd123456789, 64'd987654321, 1, "b2b_first");
      do_op(4'd0, 64'hDEAD_BEEF, 64'hCAFE, 1, "b2b_second");
      go_idle("b2b");

      // Reset in the middle of a multiply
      @(negedge clk);
      valid_i = 1'b1; op_i = 4'd0; rs1_i = 64'd5; rs2_i = 64'd6; ex_hold_i = 1'b1;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      valid_i = 1'b0;
      #1;
      check("midreset stall", 64'(stall_req_o), 64'd0);
      check("midreset valid", 64'(result_valid_o), 64'd0);
      check("midreset result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      ex_hold_i = 1'b0;
      do_op(4'd7, -64'd17, 64'd5, 1, "after_reset");
      go_idle("after_reset");

      // Randomized ops against the reference model
      for (int k = 0; k < 40; k++) begin
         rop = 4'($urandom_range(0, 15));
         do_op(rop, pick(), pick(), $urandom_range(1, 3), $sformatf("rand%0d_op%0d", k, rop));
      end
      go_idle("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
